// File: rtl/io_map_pkg.sv
// Shared I/O map for the TinyComp peripheral ports: addresses, status bit
// positions and the UART receive state encoding.
package io_map_pkg;

  localparam logic [31:0] LED_ADDR  = 32'h0000_03ff;
  localparam logic [31:0] DATA_ADDR = 32'h0000_03fe;
  localparam logic [31:0] STAT_ADDR = 32'h0000_03fd;

  localparam int AVAIL_BIT = 0;
  localparam int FULL_BIT  = 1;
  localparam int OVR_BIT   = 2;
  localparam int FERR_BIT  = 3;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/io_uart_rx_port_if.sv
// CPU I/O read bus as seen by an input port: address/strobe from the CPU,
// data/ready back from the peripheral.
interface io_uart_rx_port_if;
  logic [31:0] IOaddr;
  logic        InStrobe;
  logic [31:0] InData;
  logic        InRdy;

  modport master (output IOaddr, output InStrobe, input InData, input InRdy);
  modport slave  (input IOaddr, input InStrobe, output InData, output InRdy);
endinterface

// File: rtl/io_uart_rx_port_rx_core.sv
// 8N1 receiver: rx synchroniser, bit-timing FSM and LSB-first shift register.
// Emits single-cycle byte_valid / frame_err pulses at the stop-bit sample.
module uart_rx_core
  import io_map_pkg::*;
#(
  parameter int CLKS_PER_BIT = 347
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] rx_byte,
  output logic       frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             rx_meta;
  logic             rx_sync;
  rx_state_t        state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          clk_cnt <= '0;
          bit_cnt <= '0;
          if (!rx_sync) state <= START;
        end
        START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt <= '0;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP: begin
          if (clk_cnt == FULL_LAST) begin
            clk_cnt    <= '0;
            byte_valid <= rx_sync;
            frame_err  <= !rx_sync;
            state      <= IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Shift register is pure data: no reset, loaded only at DATA sample points.
  always_ff @(posedge clk) begin
    if (state == DATA && clk_cnt == FULL_LAST) shreg <= {rx_sync, shreg[7:1]};
  end

  assign rx_byte = shreg;

endmodule

// File: rtl/io_uart_rx_port.sv
// Memory-mapped UART receive port: serial receiver, byte FIFO and the CPU
// I/O read decode for the data and status registers.
module io_uart_rx_port
  import io_map_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 347,
  parameter int          FIFO_DEPTH   = 4,
  parameter logic [31:0] DATA_ADDR    = io_map_pkg::DATA_ADDR,
  parameter logic [31:0] STAT_ADDR    = io_map_pkg::STAT_ADDR
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              rx,
  io_uart_rx_port_if.slave  bus,
  output logic              rx_irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic             byte_valid;
  logic [7:0]       rx_byte;
  logic             frame_err;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_next;
  logic             ovr;
  logic             ferr;

  logic             empty;
  logic             full;
  logic             data_sel;
  logic             stat_sel;
  logic             pop;
  logic             push;
  logic             ovr_set;
  logic [31:0]      status;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk       (clk),
    .rst       (Reset),
    .rx        (rx),
    .byte_valid(byte_valid),
    .rx_byte   (rx_byte),
    .frame_err (frame_err)
  );

  assign empty    = (count == '0);
  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign data_sel = bus.InStrobe && (bus.IOaddr == DATA_ADDR);
  assign stat_sel = bus.InStrobe && (bus.IOaddr == STAT_ADDR);
  assign pop      = data_sel && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign push     = byte_valid && (!full || pop);
  assign ovr_set  = byte_valid && full && !pop;

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovr    <= 1'b0;
      ferr   <= 1'b0;
      rx_irq <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count  <= count_next;
      rx_irq <= (count_next != '0);
      // New error events take priority over the clear-on-status-read.
      if (ovr_set)       ovr <= 1'b1;
      else if (stat_sel) ovr <= 1'b0;
      if (frame_err)     ferr <= 1'b1;
      else if (stat_sel) ferr <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_byte;
  end

  always_comb begin
    status            = '0;
    status[AVAIL_BIT] = !empty;
    status[FULL_BIT]  = full;
    status[OVR_BIT]   = ovr;
    status[FERR_BIT]  = ferr;
  end

  // Idle reads return 0 with InRdy=1 so several input ports can be OR-ed.
  always_comb begin
    bus.InData = '0;
    bus.InRdy  = 1'b1;
    if (data_sel) begin
      if (empty) bus.InRdy  = 1'b0;
      else       bus.InData = {24'b0, mem[rd_ptr]};
    end else if (stat_sel) begin
      bus.InData = status;
    end
  end

endmodule

// File: doc/io_uart_rx_port.md
Name: io_uart_rx_port

Overview:
Memory-mapped UART receive peripheral on the TinyComp I/O input path. It is the read-side counterpart of the LED output latch.
- Deserialises 8N1 serial data at 40 MHz.
- Buffers received bytes in a small FIFO.
- Answers CPU I/O reads (InStrobe/IOaddr) with InData/InRdy, stalling the CPU on a data read while the FIFO is empty.

Parameters:
CLKS_PER_BIT, 347, clk cycles per bit (40 MHz / 115200).
FIFO_DEPTH, 4, receive FIFO entries; power of two, at least 2.
DATA_ADDR, 32'h000003fe, I/O address of the RX data register.
STAT_ADDR, 32'h000003fd, I/O address of the status register.

Ports:
clk  in  1  system clock (clk40 domain)
Reset  in  1  synchronous, active-high reset
rx  in  1  asynchronous serial input, idle high
IOaddr  in  32  CPU I/O address
InStrobe  in  1  CPU I/O read strobe; held until InRdy
InData  out  32  read data to CPU
InRdy  out  1  read-complete handshake to CPU
rx_irq  out  1  high while the FIFO is non-empty

Behaviour:
- Only clk is used; Reset is synchronous and active-high. All state is updated on the rising edge of clk.
- Reset state:
  - FIFO empty; overrun and framing-error flags cleared.
  - RX FSM in IDLE; rx synchroniser loaded with 1.
  - Outputs: InData=0, InRdy=1, rx_irq=0.
- Reset mid-frame abandons the partial byte. After reset the FSM waits for a fresh falling edge.
- rx passes through a 2-flop synchroniser. All references to rx below mean the synchronised value.
- RX FSM:
  - IDLE: when rx=0, go to START and clear the bit counter.
  - START: count CLKS_PER_BIT/2 cycles, then sample. If rx=1 (glitch), return to IDLE with no flag set. Otherwise go to DATA.
  - DATA: sample every CLKS_PER_BIT cycles, LSB first, 8 bits, shifting into a shift register. After bit 7, go to STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rx=1: push the byte.
    - rx=0: discard the byte and set ferr (sticky).
    - In both cases return to IDLE on the following cycle. No wait for the line to go high.
- FIFO:
  - Push occurs when STOP samples rx=1.
  - If full and no pop in the same cycle, the byte is dropped and ovr is set (sticky).
  - Push and pop in the same cycle: both occur and the count is unchanged; this holds even when full.
  - Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.
- CPU read decode (combinational outputs):
  - InStrobe=1, IOaddr=DATA_ADDR, FIFO non-empty: InData={24'b0, head byte}, InRdy=1. The FIFO pops on this clock edge.
  - InStrobe=1, IOaddr=DATA_ADDR, FIFO empty: InRdy=0 and InData=0 (CPU stalls). When a push lands, the next cycle reads it out.
  - InStrobe=1, IOaddr=STAT_ADDR: InRdy=1 and InData={28'b0, ferr, ovr, full, !empty}. ovr and ferr clear on that edge. If a new error event occurs in the same cycle, it wins and the flag stays set.
  - Any other case: InData=0 and InRdy=1, so top level can OR multiple ports.
- One pop per clock edge while the strobe is held. The CPU deasserts InStrobe the cycle after InRdy=1, so no double pop occurs.
- rx_irq = !empty, registered from the count.

Decomposition:
- Shared package io_map_pkg holds LED_ADDR (32'h3ff), DATA_ADDR, STAT_ADDR, the status bit indices (AVAIL=0, FULL=1, OVR=2, FERR=3), and the RX state enum (IDLE, START, DATA, STOP).
- One sub-module, uart_rx_core: synchroniser, FSM and shift register, with byte_valid pulse, byte[7:0] and frame_err pulse outputs.
- The FIFO and read decode stay inline in io_uart_rx_port.

Test Plan:
- Reset, then drive frame 0x5A and strobe DATA_ADDR -> InRdy=1, InData=32'h0000005a; status then reads 32'h0.
- Strobe DATA_ADDR with FIFO empty for 20 cycles, then send 0xC3 -> InRdy=0 throughout; InRdy=1 with InData=32'hc3 only after the STOP sample, one pop.
- Send 5 bytes 0x01..0x05 with no reads (depth 4) -> status=32'h7 (ovr, full, avail); reads return 1,2,3,4; the following status read=32'h0.
- Frame 0x81 with stop bit=0 -> no push; status=32'h8; a second status read=32'h0.
- 0.3-bit low glitch on rx -> FSM returns to IDLE; status stays 32'h0.
- Assert Reset midway through data bit 3 of a frame, release, then send 0x7E -> only 0x7E is read and rx_irq falls after the pop.
